// File: rtl/game_over_ctrl.sv
// Game-flow back end: runs a play session, tracks lives/level, holds the death and GAME OVER screens, then requests a restart.
// All outputs registered, 1-cycle input-to-output latency; optional high-score register enabled by `define HIGH_SCORE_EN.
module game_over_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int LIVES_W      = 3,
    parameter int LEVEL_W      = 4,
    parameter int DEATH_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int TMR_W        = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               game_start,
    input  logic               frame_tick,
    input  logic               player_hit,
    input  logic               level_clear,
    output logic               playing,
    output logic               freeze,
    output logic               game_over,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level,
    output logic               restart_req
`ifdef HIGH_SCORE_EN
    ,
    input  logic [15:0]        score_in,
    output logic [15:0]        high_score
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
    localparam logic [TMR_W-1:0]   DEATH_END = TMR_W'(DEATH_FRAMES - 1);
    localparam logic [TMR_W-1:0]   OVER_END  = TMR_W'(OVER_FRAMES - 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               restart_q, restart_d;
    logic               playing_q, playing_d;
    logic               freeze_q, freeze_d;
    logic               game_over_q, game_over_d;
`ifdef HIGH_SCORE_EN
    logic [15:0]        high_score_q, high_score_d;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lives_d   = lives_q;
        level_d   = level_q;
        restart_d = 1'b0;
`ifdef HIGH_SCORE_EN
        high_score_d = high_score_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (game_start) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_W'(LIVES_INIT);
                    level_d = LEVEL_W'(1);
                    timer_d = '0;
                end
            end
            S_PLAY: begin
                // A hit wins over a simultaneous level clear; the clear is lost.
                if (player_hit) begin
                    state_d = S_DYING;
                    timer_d = '0;
                end else if (level_clear && level_q != LEVEL_MAX) begin
                    level_d = level_q + 1'b1;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (timer_q == DEATH_END) begin
                        timer_d = '0;
                        if (lives_q == LIVES_W'(1)) begin
                            lives_d = '0;
                            state_d = S_OVER;
`ifdef HIGH_SCORE_EN
                            if (score_in > high_score_q) high_score_d = score_in;
`endif
                        end else begin
                            lives_d = lives_q - 1'b1;
                            state_d = S_PLAY;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (frame_tick) begin
                    if (timer_q == OVER_END) begin
                        timer_d   = '0;
                        state_d   = S_IDLE;
                        restart_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are decoded from the next state so they land in the same cycle as the state change.
        playing_d   = (state_d == S_PLAY);
        freeze_d    = (state_d == S_DYING) || (state_d == S_OVER);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            lives_q     <= '0;
            level_q     <= '0;
            restart_q   <= 1'b0;
            playing_q   <= 1'b0;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            restart_q   <= restart_d;
            playing_q   <= playing_d;
            freeze_q    <= freeze_d;
            game_over_q <= game_over_d;
        end
    end

`ifdef HIGH_SCORE_EN
    // Survives new games; only Reset clears the best score.
    always_ff @(posedge Clk) begin
        if (Reset) high_score_q <= '0;
        else       high_score_q <= high_score_d;
    end
    assign high_score = high_score_q;
`endif

    assign playing     = playing_q;
    assign freeze      = freeze_q;
    assign game_over   = game_over_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign restart_req = restart_q;

endmodule
